// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel, W-bit registered stream multiplexer.
// One beat per cycle is picked either by an external select (MODE=0) or by a
// fair round-robin arbiter (MODE=1) and held in a one-entry output register.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_data  [N*W]    channel k at bits [k*W +: W]
//   in_valid [N]      per-channel valid
//   in_ready [N]      per-channel ready (combinational, one-hot or zero)
//   sel      [CW]     channel select, MODE=0 only
//   out_data [W]      registered selected data
//   out_chan [CW]     registered index of the source channel
//   out_valid         output register holds a beat
//   out_ready         sink accepts the beat
module mux_rr_n #(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int MODE = 1,
    localparam int CW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [CW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);

    // Index space is padded to a power of two so any CW-bit index is legal;
    // the padding channels are never valid.
    localparam int NP = 1 << CW;

    logic [W-1:0]  ch_data [NP];
    logic [NP-1:0] vld_pad;

    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] chan_q, chan_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] ptr_q, ptr_d;

    logic          ld;
    logic          acc;
    logic          sel_vld;
    logic          rr_vld;
    logic [CW-1:0] rr_gnt;
    logic [CW-1:0] k_idx;
    logic          gnt_vld;
    logic [CW-1:0] gnt;

    for (genvar k = 0; k < NP; k++) begin : g_ch
        if (k < N) begin : g_real
            assign ch_data[k] = in_data[k*W +: W];
        end else begin : g_pad
            assign ch_data[k] = '0;
        end
    end

    assign vld_pad = NP'(in_valid);

    // Register may load when empty or being drained this same cycle.
    assign ld = !valid_q || out_ready;

    assign sel_vld = (int'(sel) < N) && vld_pad[sel];

    // Search order is ptr+1, ptr+2, ... ptr (mod N). Iterating from the
    // farthest offset down lets the nearest valid channel win last.
    always_comb begin
        rr_vld = 1'b0;
        rr_gnt = '0;
        k_idx  = '0;
        for (int i = N; i >= 1; i--) begin
            k_idx = CW'((int'(ptr_q) + i) % N);
            if (vld_pad[k_idx]) begin
                rr_vld = 1'b1;
                rr_gnt = k_idx;
            end
        end
    end

    assign gnt_vld = (MODE == 0) ? sel_vld : rr_vld;
    assign gnt     = (MODE == 0) ? sel : rr_gnt;

    // No handshake can complete while reset is held.
    assign acc = gnt_vld && ld && !rst;

    always_comb begin
        in_ready = '0;
        if (acc) begin
            in_ready = N'(1) << gnt;
        end
    end

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (acc) begin
            data_d  = ch_data[gnt];
            chan_d  = gnt;
            valid_d = 1'b1;
            if (MODE == 1) begin
                ptr_d = gnt;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Pointer resets to N-1 so channel 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= CW'(N - 1);
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Testbench for mux_rr_n: round-robin, select-mode and out-of-range select
// instances, with queue-based scoreboards checked by per-instance monitors.
module tb_mux_rr_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: N=4, MODE=1 (round-robin)
    logic        rst_a;
    logic [31:0] a_din;
    logic [3:0]  a_vin, a_irdy;
    logic [1:0]  a_sel, a_chan;
    logic [7:0]  a_odata;
    logic        a_ov, a_ordy;

    // Instance B: N=4, MODE=0 (select)
    logic        rst_b;
    logic [31:0] b_din;
    logic [3:0]  b_vin, b_irdy;
    logic [1:0]  b_sel, b_chan;
    logic [7:0]  b_odata;
    logic        b_ov, b_ordy;

    // Instance C: N=3, MODE=0 (select, out-of-range index possible)
    logic [23:0] c_din;
    logic [2:0]  c_vin, c_irdy;
    logic [1:0]  c_sel, c_chan;
    logic [7:0]  c_odata;
    logic        c_ov, c_ordy;

    logic [9:0] qa[$];
    logic [9:0] qb[$];
    logic [9:0] qc[$];
    logic [9:0] ea, eb, ec;

    mux_rr_n #(.N(4), .W(8), .MODE(1)) u_a (
        .clk(clk), .rst(rst_a), .in_data(a_din), .in_valid(a_vin),
        .in_ready(a_irdy), .sel(a_sel), .out_data(a_odata),
        .out_chan(a_chan), .out_valid(a_ov), .out_ready(a_ordy)
    );

    mux_rr_n #(.N(4), .W(8), .MODE(0)) u_b (
        .clk(clk), .rst(rst_b), .in_data(b_din), .in_valid(b_vin),
        .in_ready(b_irdy), .sel(b_sel), .out_data(b_odata),
        .out_chan(b_chan), .out_valid(b_ov), .out_ready(b_ordy)
    );

    mux_rr_n #(.N(3), .W(8), .MODE(0)) u_c (
        .clk(clk), .rst(rst_b), .in_data(c_din), .in_valid(c_vin),
        .in_ready(c_irdy), .sel(c_sel), .out_data(c_odata),
        .out_chan(c_chan), .out_valid(c_ov), .out_ready(c_ordy)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a beat seen valid&&ready at the falling edge is consumed
    // on the next rising edge.
    always @(negedge clk) begin
        if (!rst_a && a_ov && a_ordy) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL a_beat unexpected got=%h want=none",
                         {a_chan, a_odata});
            end else begin
                ea = qa.pop_front();
                check("a_beat", {22'd0, a_chan, a_odata}, {22'd0, ea});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && b_ov && b_ordy) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL b_beat unexpected got=%h want=none",
                         {b_chan, b_odata});
            end else begin
                eb = qb.pop_front();
                check("b_beat", {22'd0, b_chan, b_odata}, {22'd0, eb});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && c_ov && c_ordy) begin
            if (qc.size() == 0) begin
                total++; bad++;
                $display("FAIL c_beat unexpected got=%h want=none",
                         {c_chan, c_odata});
            end else begin
                ec = qc.pop_front();
                check("c_beat", {22'd0, c_chan, c_odata}, {22'd0, ec});
            end
        end
    end

    logic [3:0] fair_rdy [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [9:0] fair_exp [8] = '{{2'd0, 8'hA0}, {2'd1, 8'hA1},
                                 {2'd2, 8'hA2}, {2'd3, 8'hA3},
                                 {2'd0, 8'hA0}, {2'd1, 8'hA1},
                                 {2'd2, 8'hA2}, {2'd3, 8'hA3}};
    logic [3:0] wrap_rdy [3] = '{4'b0010, 4'b1000, 4'b0010};
    logic [9:0] wrap_exp [3] = '{{2'd1, 8'hA1}, {2'd3, 8'hA3},
                                 {2'd1, 8'hA1}};

    initial begin
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        a_din  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        a_vin  = '0;
        a_sel  = '0;
        a_ordy = 1'b0;
        b_din  = {8'h03, 8'h22, 8'h01, 8'h30};
        b_vin  = '0;
        b_sel  = '0;
        b_ordy = 1'b0;
        c_din  = {8'hC2, 8'hC1, 8'hC0};
        c_vin  = '0;
        c_sel  = '0;
        c_ordy = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, a_ov}, 32'd0);
        check("rst_data", {24'd0, a_odata}, 32'd0);
        check("rst_chan", {30'd0, a_chan}, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Fairness: all channels valid, sink always ready
        a_vin  = 4'b1111;
        a_ordy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("fair_rdy", {28'd0, a_irdy}, {28'd0, fair_rdy[k]});
            qa.push_back(fair_exp[k]);
            step();
        end

        // Skip and wrap from ptr=3 with only channels 1 and 3 valid
        a_vin = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("wrap_rdy", {28'd0, a_irdy}, {28'd0, wrap_rdy[k]});
            check("wrap_skip", {28'd0, a_irdy & 4'b0101}, 32'd0);
            qa.push_back(wrap_exp[k]);
            step();
        end

        // Backpressure: hold beat A2 from channel 2 for 3 cycles
        a_vin = 4'b1111;
        #1;
        check("bp_grant2", {28'd0, a_irdy}, 32'b0100);
        qa.push_back({2'd2, 8'hA2});
        step();
        a_ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_rdy", {28'd0, a_irdy}, 32'd0);
            check("bp_data", {24'd0, a_odata}, 32'hA2);
            check("bp_chan", {30'd0, a_chan}, 32'd2);
            check("bp_valid", {31'd0, a_ov}, 32'd1);
            step();
        end
        a_ordy = 1'b1;
        #1;
        check("bp_grant3", {28'd0, a_irdy}, 32'b1000);
        qa.push_back({2'd3, 8'hA3});
        step();

        // Simultaneous drain and load on channel 1
        a_din[15:8] = 8'h11;
        a_vin       = 4'b0010;
        #1;
        check("dl_rdy", {28'd0, a_irdy}, 32'b0010);
        check("dl_valid_pre", {31'd0, a_ov}, 32'd1);
        qa.push_back({2'd1, 8'h11});
        step();
        check("dl_valid", {31'd0, a_ov}, 32'd1);
        check("dl_data", {24'd0, a_odata}, 32'h11);
        check("dl_chan", {30'd0, a_chan}, 32'd1);
        a_vin = 4'b0000;
        step();

        // Reset mid-transfer with a held beat
        a_din[15:8] = 8'hA1;
        a_vin       = 4'b0001;
        a_ordy      = 1'b0;
        #1;
        check("mr_rdy", {28'd0, a_irdy}, 32'b0001);
        step();
        check("mr_held", {31'd0, a_ov}, 32'd1);
        #2;
        rst_a = 1'b1;
        #1;
        check("mr_valid", {31'd0, a_ov}, 32'd0);
        check("mr_data", {24'd0, a_odata}, 32'd0);
        check("mr_chan", {30'd0, a_chan}, 32'd0);
        check("mr_irdy", {28'd0, a_irdy}, 32'd0);
        step();
        check("mr_irdy2", {28'd0, a_irdy}, 32'd0);
        rst_a  = 1'b0;
        a_vin  = 4'b1111;
        a_ordy = 1'b1;
        #1;
        check("mr_ptr", {28'd0, a_irdy}, 32'b0001);
        qa.push_back({2'd0, 8'hA0});
        step();
        a_vin = 4'b0000;
        step();

        // Select mode
        b_sel  = 2'd0;
        b_vin  = 4'b0001;
        b_ordy = 1'b1;
        #1;
        check("sel_rdy0", {28'd0, b_irdy}, 32'b0001);
        qb.push_back({2'd0, 8'h30});
        step();
        b_sel = 2'd2;
        b_vin = 4'b1011;
        #1;
        check("sel_norq", {28'd0, b_irdy}, 32'd0);
        check("sel_vhold", {31'd0, b_ov}, 32'd1);
        step();
        check("sel_drain", {31'd0, b_ov}, 32'd0);
        check("sel_norq2", {28'd0, b_irdy}, 32'd0);
        step();
        check("sel_idle", {31'd0, b_ov}, 32'd0);
        b_din[23:16] = 8'h5C;
        b_vin        = 4'b1111;
        #1;
        check("sel_rdy2", {28'd0, b_irdy}, 32'b0100);
        qb.push_back({2'd2, 8'h5C});
        step();
        check("sel_valid", {31'd0, b_ov}, 32'd1);
        check("sel_data", {24'd0, b_odata}, 32'h5C);
        check("sel_chan", {30'd0, b_chan}, 32'd2);
        b_vin = 4'b0000;
        step();

        // Out-of-range select on a 3-channel instance
        c_sel  = 2'd3;
        c_vin  = 3'b111;
        c_ordy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("oor_rdy", {29'd0, c_irdy}, 32'd0);
            check("oor_valid", {31'd0, c_ov}, 32'd0);
            step();
        end
        c_sel = 2'd1;
        #1;
        check("c_rdy1", {29'd0, c_irdy}, 32'b010);
        qc.push_back({2'd1, 8'hC1});
        step();
        check("c_valid", {31'd0, c_ov}, 32'd1);
        check("c_data", {24'd0, c_odata}, 32'hC1);
        check("c_chan", {30'd0, c_chan}, 32'd1);
        c_vin = 3'b000;
        step();
        step();

        check("qa_empty", qa.size(), 32'd0);
        check("qb_empty", qb.size(), 32'd0);
        check("qc_empty", qc.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It selects one channel per cycle, either by an external select or by a fair round-robin arbiter, and holds the selected beat in a one-entry output register. It is the next generation of the team's combinational 2:1 mux, for datapaths that merge several streaming sources into one sink that may stall.

## Interface
- `N`, default 4: number of input channels, must be ≥ 2.
- `W`, default 8: data width per channel.
- `MODE`, default 1: 0 = external select, 1 = round-robin.
- `CW`, derived as $clog2(N): width of the channel index.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input N*W: channel k occupies bits [k*W +: W].
- `in_valid` input N: per-channel valid.
- `in_ready` output N: per-channel ready. Combinational; at most one bit high.
- `sel` input CW: channel select. Used only when MODE=0.
- `out_data` output W: registered selected data.
- `out_chan` output CW: registered index of the channel that supplied `out_data`.
- `out_valid` output 1: output register holds a beat.
- `out_ready` input 1: sink accepts the beat.

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0. Round-robin pointer `ptr`=N-1, so channel 0 has first priority.
- Load enable: `ld` = !out_valid || out_ready. The register may load when it is empty or being drained in the same cycle.
- Grant, MODE=0:
  - `g` = sel when `sel` < N and in_valid[sel] is high.
  - Otherwise there is no grant.
  - A valid on a non-selected channel is ignored.
  - `sel` ≥ N never grants.
- Grant, MODE=1:
  - `g` is the first k with in_valid[k] high, searching (ptr+1) mod N, (ptr+2) mod N, … up to ptr.
  - Otherwise there is no grant.
- `in_ready[g]` = ld when a grant exists. All other `in_ready` bits are 0.
- Accept: a transfer on channel g occurs when in_valid[g] && in_ready[g]. On accept, at the next edge:
  - `out_data` <= channel g data,
  - `out_chan` <= g,
  - `out_valid` <= 1,
  - `ptr` <= g (MODE=1 only).
- No accept, but `out_ready` is high: `out_valid` <= 0. `out_data` and `out_chan` keep their last values.
- `out_valid` high and `out_ready` low: all output registers hold.
- `ptr` changes only on accept. It never moves on idle cycles or stalls.
- Fairness (MODE=1): with every channel continuously valid and `out_ready` high, grants cycle 0,1,…,N-1,0,…
- Starvation bound (MODE=1): a continuously valid channel is accepted within N accepts.
- Wrap-around: when `ptr`=N-1, the search starts at channel 0.

## Timing
- Latency: accept at edge t, so `out_valid`/`out_data` are valid after edge t.
- Throughput: 1 beat per cycle while `out_ready` stays high, including simultaneous drain and load.
- `in_ready` depends combinationally on `out_valid`, `out_ready`, `in_valid`, `sel` and `ptr`. There is no combinational path from any input to `out_data`, `out_chan` or `out_valid`.
- Output stability: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_chan` must not change.
- Reset asserted mid-transfer: outputs and `ptr` go to their reset values immediately, without waiting for a clock. The held beat is discarded. All `in_ready` bits are low while `rst` is high.
- First accept is possible on the first rising edge after `rst` deasserts.

## Test plan
- Reset: drive `rst`=1 mid-stream with `out_valid`=1.
  - Expect `out_valid`=0, `out_data`=0x00, `out_chan`=0 before the next `clk` edge.
  - Expect `in_ready`=4'b0000 while `rst` is high.
- Round-robin fairness: N=4, MODE=1, all `in_valid`=4'b1111, channel k data = 0xA0+k, `out_ready`=1 for 8 cycles.
  - Expect `out_chan` sequence 0,1,2,3,0,1,2,3.
  - Expect `out_data` sequence 0xA0,0xA1,0xA2,0xA3,…
- Skip and wrap: `in_valid`=4'b1010 after `ptr`=3.
  - Expect grant to channel 1, then 3, then 1.
  - Channels 0 and 2 never see `in_ready`.
- Backpressure: `out_ready`=0 for 3 cycles holding beat 0xA2 from channel 2, `in_valid`=4'b1111.
  - Expect `in_ready`=0 and `out_data`=0xA2 stable for all 3 cycles.
  - After `out_ready` rises, expect the next grant to channel 3 with no lost or duplicated beat.
- Select mode: MODE=0, `sel`=2, `in_valid`=4'b1011.
  - Expect no grant and `out_valid` falling once drained.
  - Set `in_valid`[2]=1 with data 0x5C: expect `out_data`=0x5C and `out_chan`=2 one cycle later.
  - `sel`=3 with N=3 (out of range): expect no `in_ready` bit ever high.
- Simultaneous drain and load: `out_valid`=1, `out_ready`=1, channel 1 valid with 0x11.
  - Expect `in_ready`[1]=1 in that cycle.
  - Expect `out_data`=0x11 and `out_valid`=1 after the edge, with no bubble cycle.
